frame_streamer: RTL and testbench

Double-buffered 8x8 RGB frame store that sits directly upstream of `colorshield`, driving its `write_en` / `pixel_addr` / `pixel_value` inputs and consuming its `ready`. A producer (animation logic, UART loader) writes a complete frame into the back bank, then requests a swap. The streamer continuously rescans the front bank into the shield one pixel per ready handshake. Swaps take effect only at frame boundaries, so the matrix never displays a torn frame.

---
 rtl/frame_streamer.sv | 212 +++++++++++++++++++++
 tb/tb_frame_streamer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_streamer.sv
// -----------------------------------------------------------------------------
// frame_streamer
//
// Double-buffered RGB frame store feeding a colorshield-style pixel sink.
// A producer fills the back bank through the host write port and then asks
// for a swap. The streamer rescans the front bank forever, one pixel per
// shield handshake, and only exchanges banks at a frame boundary so the
// display never shows a half-old / half-new frame.
//
// Parameters
//   ADDR_W       pixel address width; a frame is 2**ADDR_W pixels
//   PIX_W        pixel width, packed {R, G, B}
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset (memory contents are kept)
//   wr_en        host write strobe, always targets the back bank
//   wr_addr      host write address
//   wr_data      host write data
//   swap_req     single-cycle request to exchange front and back banks
//   shield_ready sink ready
//   write_en     one-cycle pixel write strobe to the sink
//   pixel_addr   pixel address to the sink
//   pixel_value  pixel data to the sink
//   front_bank   bank currently being displayed
//   swap_pending swap accepted, waiting for the end of the current frame
//   frame_done   one-cycle pulse alongside the write of the last pixel
//
// Handshake: write_en is the valid. The sink's shield_ready is sampled only
// while the FSM sits in WAIT with write_en low; when it is seen high the next
// cycle carries write_en = 1 for exactly one cycle, and that single cycle is
// the transfer. pixel_addr / pixel_value are held from the WAIT cycle through
// the write_en cycle and only change on the following FETCH->WAIT edge.
// -----------------------------------------------------------------------------
module frame_streamer #(
  parameter int ADDR_W = 6,
  parameter int PIX_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              swap_req,
  input  logic              shield_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [PIX_W-1:0]  pixel_value,
  output logic              front_bank,
  output logic              swap_pending,
  output logic              frame_done
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  // ---------------------------------------------------------------------------
  // FSM state. state_q is the single point to observe the controller from a
  // bound checker: IDLE (not streaming), FETCH (memory read in flight),
  // WAIT (pixel presented, waiting for the sink).
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Control strobes decoded from the state.
  logic start;   // first swap out of IDLE
  logic fetch;   // read address is being presented to the front bank
  logic issue;   // sink handshake: next cycle carries write_en
  logic last_px; // the pixel being issued is the last one of the frame
  logic apply;   // a pending swap takes effect on this edge

  // Datapath registers.
  logic [ADDR_W-1:0] rd_addr_q;

  // Both banks live in one array; the bank index is the address MSB.
  logic [PIX_W-1:0] mem [0:2*DEPTH-1];

  // ---------------------------------------------------------------------------
  // Process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic. Once streaming has started there is no path
  // back to IDLE except reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (swap_req) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (shield_ready && !write_en) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: output / control decode. shield_ready is only looked at in
  // WAIT; its value during FETCH has no effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    start = 1'b0;
    fetch = 1'b0;
    issue = 1'b0;
    unique case (state_q)
      S_IDLE:  start = swap_req;
      S_FETCH: fetch = 1'b1;
      S_WAIT:  issue = shield_ready && !write_en;
      default: begin
        start = 1'b0;
        fetch = 1'b0;
        issue = 1'b0;
      end
    endcase
  end

  assign last_px = (rd_addr_q == LAST_ADDR);
  assign apply   = issue && last_px && swap_pending;

  // ---------------------------------------------------------------------------
  // Host write port. Always lands in the back bank as seen *before* this edge,
  // so a write on the same edge a swap is applied goes into the bank that is
  // about to become the front bank. Memory is deliberately not reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{~front_bank, wr_addr}] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read address and sink-facing outputs.
  // pixel_value doubles as the synchronous read register of the front bank:
  // the address is presented in FETCH and the data is captured on the
  // FETCH->WAIT edge, giving the one-cycle read latency.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr_q   <= '0;
      write_en    <= 1'b0;
      frame_done  <= 1'b0;
      pixel_addr  <= '0;
      pixel_value <= '0;
    end else begin
      write_en   <= issue;
      frame_done <= issue && last_px;

      if (start) begin
        rd_addr_q <= '0;
      end else if (issue) begin
        // Natural wrap from LAST_ADDR back to 0 starts the next rescan.
        rd_addr_q <= rd_addr_q + 1'b1;
      end

      if (fetch) begin
        pixel_addr  <= rd_addr_q;
        pixel_value <= mem[{front_bank, rd_addr_q}];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bank selection and swap bookkeeping.
  // In IDLE a swap is applied immediately and never becomes pending. While
  // streaming, a request is remembered (once; repeats are absorbed) and applied
  // on the edge that issues the last pixel. A request arriving on that very
  // edge re-arms the pending flag for the following frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      if (start || apply) begin
        front_bank <= ~front_bank;
      end

      if (state_q != S_IDLE) begin
        if (apply) begin
          swap_pending <= swap_req;
        end else if (swap_req) begin
          swap_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_frame_streamer
//
// Directed bench for frame_streamer with default parameters (64 pixels of
// 24 bits). The first frame after a swap out of IDLE is checked against a
// table of hand-computed cycle vectors; the remaining corner cases (swap
// while streaming, random sink stalls, write on the swap edge, mid-frame
// reset) are short hand-written sequences. Outputs are sampled 1 ns after
// the rising edge, inputs are changed at the same point.
// -----------------------------------------------------------------------------
module tb_frame_streamer;

  localparam int AW = 6;
  localparam int PW = 24;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic          swap_req;
  logic          shield_ready;
  logic          write_en;
  logic [AW-1:0] pixel_addr;
  logic [PW-1:0] pixel_value;
  logic          front_bank;
  logic          swap_pending;
  logic          frame_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  frame_streamer #(
    .ADDR_W(AW),
    .PIX_W (PW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .shield_ready(shield_ready),
    .write_en    (write_en),
    .pixel_addr  (pixel_addr),
    .pixel_value (pixel_value),
    .front_bank  (front_bank),
    .swap_pending(swap_pending),
    .frame_done  (frame_done)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [PW-1:0] exp_q[$];

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [PW-1:0] val;
    logic          fd;
  } vec_t;

  vec_t vecs [12];

  // ---------------------------------------------------------------------------
  // Driver / helper tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_we(input int budget, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!write_en && n < budget);
    check({name, "_we_seen"}, 32'(write_en), 32'd1);
  endtask

  task automatic wait_fd(input int budget, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!frame_done && n < budget);
    check({name, "_fd_seen"}, 32'(frame_done), 32'd1);
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic fill_bank(input int kind);
    wr_en = 1'b1;
    for (int a = 0; a < 64; a++) begin
      wr_addr = a[AW-1:0];
      wr_data = (kind == 0) ? pat_a(a) : (kind == 1) ? 24'h00FF00 : pat_b(a);
      tick();
    end
    wr_en = 1'b0;
  endtask

  function automatic logic [PW-1:0] pat_a(input int a);
    logic [7:0] r;
    r = a[7:0];
    return {r, 16'h0000};
  endfunction

  function automatic logic [PW-1:0] pat_b(input int a);
    logic [5:0] g;
    g = a[5:0];
    return {8'h5A, 2'b00, g, 8'hA5};
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int we_cnt;
    int fd_cnt;
    int back2back;
    int drops;
    int n;
    int got;
    int viol;
    logic prev_ready;
    logic last_we;
    logic [AW-1:0] last_addr;
    logic [PW-1:0] last_val;
    logic [PW-1:0] exp_v;

    // First-frame timeline after the swap out of IDLE (edge 0).
    //              cyc  we    addr   value        fd
    vecs[0]  = '{  1, 1'b0, 6'd0,  24'h000000, 1'b0};
    vecs[1]  = '{  2, 1'b0, 6'd0,  24'h000000, 1'b0};
    vecs[2]  = '{  3, 1'b1, 6'd0,  24'h000000, 1'b0};
    vecs[3]  = '{  4, 1'b0, 6'd1,  24'h010000, 1'b0};
    vecs[4]  = '{  5, 1'b1, 6'd1,  24'h010000, 1'b0};
    vecs[5]  = '{  6, 1'b0, 6'd2,  24'h020000, 1'b0};
    vecs[6]  = '{  7, 1'b1, 6'd2,  24'h020000, 1'b0};
    vecs[7]  = '{ 65, 1'b1, 6'd31, 24'h1F0000, 1'b0};
    vecs[8]  = '{128, 1'b0, 6'd63, 24'h3F0000, 1'b0};
    vecs[9]  = '{129, 1'b1, 6'd63, 24'h3F0000, 1'b1};
    vecs[10] = '{130, 1'b0, 6'd0,  24'h000000, 1'b0};
    vecs[11] = '{131, 1'b1, 6'd0,  24'h000000, 1'b0};

    rst_n        = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    swap_req     = 1'b0;
    shield_ready = 1'b1;
    repeat (3) tick();

    // --- Reset values ---
    check("rst_write_en",     32'(write_en),     32'd0);
    check("rst_pixel_addr",   32'(pixel_addr),   32'd0);
    check("rst_pixel_value",  32'(pixel_value),  32'd0);
    check("rst_front_bank",   32'(front_bank),   32'd0);
    check("rst_swap_pending", 32'(swap_pending), 32'd0);
    check("rst_frame_done",   32'(frame_done),   32'd0);
    rst_n = 1'b1;

    // --- Idle: no streaming without a swap ---
    we_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (write_en) we_cnt++;
    end
    check("idle_no_write", 32'(we_cnt), 32'd0);
    check("idle_front",    32'(front_bank), 32'd0);
    check("idle_pending",  32'(swap_pending), 32'd0);

    // --- First frame from bank 1, table-driven ---
    fill_bank(0);
    pulse_swap();
    check("first_front",   32'(front_bank), 32'd1);
    check("first_pending", 32'(swap_pending), 32'd0);
    we_cnt = 0;
    fd_cnt = 0;
    back2back = 0;
    last_we = 1'b0;
    for (int c = 1; c <= 131; c++) begin
      if (c > 1) tick();
      if (c <= 129 && write_en) we_cnt++;
      if (frame_done) fd_cnt++;
      if (write_en && last_we) back2back++;
      last_we = write_en;
      for (int v = 0; v < 12; v++) begin
        if (vecs[v].cyc == c) begin
          check($sformatf("vec%0d_we", c),   32'(write_en),    32'(vecs[v].we));
          check($sformatf("vec%0d_addr", c), 32'(pixel_addr),  32'(vecs[v].addr));
          check($sformatf("vec%0d_val", c),  32'(pixel_value), 32'(vecs[v].val));
          check($sformatf("vec%0d_fd", c),   32'(frame_done),  32'(vecs[v].fd));
        end
      end
    end
    check("frame1_we_count", 32'(we_cnt), 32'd64);
    check("frame1_fd_count", 32'(fd_cnt), 32'd1);
    check("frame1_back2back", 32'(back2back), 32'd0);
    check("frame1_front", 32'(front_bank), 32'd1);

    // --- Swap requests mid-frame: one toggle at the frame boundary ---
    fill_bank(1);
    pulse_swap();
    check("mid_pending_set", 32'(swap_pending), 32'd1);
    repeat (5) tick();
    pulse_swap();
    repeat (5) tick();
    pulse_swap();
    check("mid_no_early_swap", 32'(front_bank), 32'd1);
    drops = 0;
    n = 0;
    while (!frame_done && n < 400) begin
      if (!swap_pending) drops++;
      tick();
      n++;
    end
    check("mid_pending_held", 32'(drops), 32'd0);
    check("mid_fd_reached",   32'(frame_done), 32'd1);
    check("mid_front_toggled", 32'(front_bank), 32'd0);
    check("mid_pending_clear", 32'(swap_pending), 32'd0);
    wait_we(8, "mid_px0");
    check("mid_px0_addr", 32'(pixel_addr), 32'd0);
    check("mid_px0_val",  32'(pixel_value), 32'h00FF00);
    wait_fd(300, "mid_next");
    check("mid_no_double_toggle", 32'(front_bank), 32'd0);
    check("mid_no_queued_swap",   32'(swap_pending), 32'd0);

    // --- Random sink stalls over a full frame of bank 1 ---
    fill_bank(2);
    pulse_swap();
    wait_fd(300, "rand_swap");
    check("rand_front", 32'(front_bank), 32'd1);
    for (int a = 0; a < 64; a++) exp_q.push_back(pat_b(a));
    prev_ready = 1'b1;
    last_we   = write_en;
    last_addr = pixel_addr;
    last_val  = pixel_value;
    got  = 0;
    viol = 0;
    n    = 0;
    while (got < 64 && n < 3000) begin
      shield_ready = 1'($urandom_range(0, 1));
      prev_ready = shield_ready;
      tick();
      n++;
      if ((pixel_addr != last_addr || pixel_value != last_val) && !last_we) viol++;
      if (write_en && last_we) viol++;
      if (write_en) begin
        check("rand_ready_before_we", 32'(prev_ready), 32'd1);
        check("rand_addr", 32'(pixel_addr), 32'(got));
        exp_v = exp_q.pop_front();
        check("rand_val", 32'(pixel_value), 32'(exp_v));
        got++;
      end
      last_we   = write_en;
      last_addr = pixel_addr;
      last_val  = pixel_value;
    end
    shield_ready = 1'b1;
    check("rand_pixel_count", 32'(got), 32'd64);
    check("rand_stability",   32'(viol), 32'd0);
    check("rand_last_fd",     32'(frame_done), 32'd1);

    // --- Host write on the edge the swap is applied ---
    pulse_swap();
    check("ws_pending", 32'(swap_pending), 32'd1);
    n = 0;
    while (!(pixel_addr == 6'd63 && !write_en) && n < 400) begin
      tick();
      n++;
    end
    check("ws_reached_last", 32'(pixel_addr), 32'd63);
    wr_en   = 1'b1;
    wr_addr = 6'd5;
    wr_data = 24'h123456;
    tick();
    wr_en = 1'b0;
    check("ws_fd",      32'(frame_done), 32'd1);
    check("ws_we",      32'(write_en), 32'd1);
    check("ws_front",   32'(front_bank), 32'd0);
    check("ws_pending_clear", 32'(swap_pending), 32'd0);
    for (int k = 0; k < 6; k++) begin
      wait_we(8, "ws_px");
      exp_v = (k == 5) ? 24'h123456 : 24'h00FF00;
      check($sformatf("ws_px%0d_addr", k), 32'(pixel_addr), 32'(k));
      check($sformatf("ws_px%0d_val", k),  32'(pixel_value), 32'(exp_v));
    end

    // --- Reset mid-frame while write_en is high ---
    wait_we(8, "mr_px6");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_write_en",     32'(write_en),     32'd0);
    check("mr_pixel_addr",   32'(pixel_addr),   32'd0);
    check("mr_pixel_value",  32'(pixel_value),  32'd0);
    check("mr_front_bank",   32'(front_bank),   32'd0);
    check("mr_swap_pending", 32'(swap_pending), 32'd0);
    check("mr_frame_done",   32'(frame_done),   32'd0);
    we_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (write_en) we_cnt++;
    end
    check("mr_idle_no_write", 32'(we_cnt), 32'd0);
    pulse_swap();
    check("mr_swap_front",   32'(front_bank), 32'd1);
    check("mr_swap_pending", 32'(swap_pending), 32'd0);
    for (int k = 0; k < 8; k++) begin
      wait_we(8, "mr_px");
      check($sformatf("mr_px%0d_addr", k), 32'(pixel_addr), 32'(k));
      check($sformatf("mr_px%0d_val", k),  32'(pixel_value), 32'(pat_b(k)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
